// File: rtl/uart_rx_pkg.sv
// Shared types and default configuration for the UART receive path blocks.
package uart_rx_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SAMPLE = 1'b1
    } state_t;

    localparam int unsigned PRESCALE_MIN     = 4;
    localparam int unsigned DEF_PRESCALE_W   = 6;
    localparam int unsigned DEF_SYNC_STAGES  = 2;
    localparam int unsigned DEF_VOTE_SAMPLES = 3;
    localparam int unsigned DEF_GLITCH_CNT_W = 8;

endpackage

// File: rtl/bit_sync.sv
// N-stage single-bit synchroniser with a configurable reset level.
module bit_sync
    import uart_rx_pkg::*;
#(
    parameter int unsigned STAGES    = DEF_SYNC_STAGES,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_start_detector.sv
// Oversampled UART start-bit qualifier: edge detect, mid-bit majority vote,
// valid/glitch pulses and a saturating glitch counter.
module uart_start_detector
    import uart_rx_pkg::*;
#(
    parameter int unsigned PRESCALE_W   = DEF_PRESCALE_W,
    parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int unsigned VOTE_SAMPLES = DEF_VOTE_SAMPLES,
    parameter int unsigned GLITCH_CNT_W = DEF_GLITCH_CNT_W
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    enable,
    input  logic                    rx_in,
    input  logic [PRESCALE_W-1:0]   prescale,
    input  logic                    glitch_clr,
    output logic                    strt_valid,
    output logic                    strt_glitch,
    output logic                    busy,
    output logic                    cfg_err,
    output logic [GLITCH_CNT_W-1:0] glitch_cnt
);

    localparam int unsigned ZERO_W    = $clog2(VOTE_SAMPLES + 1);
    localparam int unsigned MIN_RATIO = (VOTE_SAMPLES + 2 > PRESCALE_MIN) ?
                                        VOTE_SAMPLES + 2 : PRESCALE_MIN;
    localparam logic [PRESCALE_W-1:0] MIN_P  = MIN_RATIO[PRESCALE_W-1:0];
    localparam logic [PRESCALE_W-1:0] HALF_P = PRESCALE_W'(VOTE_SAMPLES >> 1);
    localparam logic [ZERO_W-1:0]     HALF_Z = ZERO_W'(VOTE_SAMPLES >> 1);

    state_t                  state;
    logic                    rx_sync;
    logic                    rx_prev;
    logic [PRESCALE_W-1:0]   edge_cnt;
    logic [ZERO_W-1:0]       zero_cnt;

    logic [PRESCALE_W-1:0]   mid;
    logic [PRESCALE_W-1:0]   win_lo;
    logic [PRESCALE_W-1:0]   win_hi;
    logic [PRESCALE_W-1:0]   last;
    logic [ZERO_W-1:0]       zero_next;
    logic                    edge_seen;
    logic                    decide;
    logic                    votes_ok;
    logic                    glitch_hit;

    bit_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync (
        .CLK (CLK),
        .RST (RST),
        .d   (rx_in),
        .q   (rx_sync)
    );

    assign cfg_err = (prescale < MIN_P);

    always_comb begin
        mid        = prescale >> 1;
        win_lo     = mid - HALF_P;
        win_hi     = mid + HALF_P;
        last       = prescale - PRESCALE_W'(1);
        zero_next  = zero_cnt + ZERO_W'((edge_cnt >= win_lo) && (edge_cnt <= win_hi) && !rx_sync);
        votes_ok   = (zero_next > HALF_Z);
        edge_seen  = enable && !cfg_err && rx_prev && !rx_sync;
        decide     = (state == SAMPLE) && enable && (edge_cnt == last);
        glitch_hit = decide && !votes_ok;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            edge_cnt    <= '0;
            zero_cnt    <= '0;
            rx_prev     <= 1'b1;
            strt_valid  <= 1'b0;
            strt_glitch <= 1'b0;
            busy        <= 1'b0;
            glitch_cnt  <= '0;
        end else begin
            rx_prev     <= rx_sync;
            strt_valid  <= 1'b0;
            strt_glitch <= 1'b0;

            if (glitch_clr) begin
                glitch_cnt <= '0;
            end else if (glitch_hit && (glitch_cnt != '1)) begin
                glitch_cnt <= glitch_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (edge_seen) begin
                        state    <= SAMPLE;
                        busy     <= 1'b1;
                        edge_cnt <= '0;
                        zero_cnt <= '0;
                    end
                end
                SAMPLE: begin
                    // Abort outranks the decision; a wrapped edge_cnt still reaches last.
                    if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (edge_cnt == last) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        strt_valid  <= votes_ok;
                        strt_glitch <= !votes_ok;
                    end else begin
                        edge_cnt <= edge_cnt + 1'b1;
                        zero_cnt <= zero_next;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
